// File: rtl/mips32_pkg.sv
// Shared definitions for the MIPS32 register file slice.
// Holds the default widths and the register file sweep FSM encoding.
package mips32_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one pending-producer flag per register.
// Ports: clock/reset, flush (drop all), set (reserve), clr (write-back), busy vector.
module regfile_scoreboard
    import mips32_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  set_en,
    input  logic [ADDR_W-1:0]     set_addr,
    input  logic                  clr_en,
    input  logic [ADDR_W-1:0]     clr_addr,
    output logic [2**ADDR_W-1:0]  busy
);

    logic [2**ADDR_W-1:0] busy_next;

    // Reserve is applied after write-back so it wins on a same-address hit.
    always_comb begin
        busy_next = busy;
        if (clr_en) begin
            busy_next[clr_addr] = 1'b0;
        end
        if (set_en) begin
            busy_next[set_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Register file with soft-clear sweep, write bypass and busy scoreboard.
// Ports: clock/reset, clear_req, NUM_RD read ports (addr/data/busy), write, reserve, ready.
module regfile_sb
    import mips32_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear_req,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic                     ready
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    rf_state_e          state;
    rf_state_e          state_next;
    logic [ADDR_W-1:0]  clr_idx;
    logic [ADDR_W-1:0]  clr_idx_next;
    logic               is_ready;
    logic               wr_fire;
    logic               rsv_fire;
    logic [DEPTH-1:0]   busy;
    logic [DATA_W-1:0]  regs [DEPTH];

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_CLEAR;
            clr_idx <= '0;
        end else begin
            state   <= state_next;
            clr_idx <= clr_idx_next;
        end
    end

    // A clear request restarts the sweep from entry 0 in either state.
    always_comb begin
        state_next   = state;
        clr_idx_next = clr_idx;
        if (clear_req) begin
            state_next   = ST_CLEAR;
            clr_idx_next = '0;
        end else begin
            unique case (state)
                ST_CLEAR: begin
                    if (clr_idx == LAST_IDX) begin
                        state_next   = ST_READY;
                        clr_idx_next = '0;
                    end else begin
                        clr_idx_next = clr_idx + ADDR_W'(1);
                    end
                end
                ST_READY: begin
                    clr_idx_next = '0;
                end
                default: begin
                    state_next   = ST_CLEAR;
                    clr_idx_next = '0;
                end
            endcase
        end
    end

    assign is_ready = (state == ST_READY);
    assign ready    = is_ready;
    assign wr_fire  = wr_en  && is_ready && (wr_addr  != '0);
    assign rsv_fire = rsv_en && is_ready && (rsv_addr != '0);

    // Storage has no reset; the sweep is what zeroes it.
    always_ff @(posedge clock) begin
        if (!is_ready) begin
            regs[clr_idx] <= '0;
        end else if (wr_fire) begin
            regs[wr_addr] <= wr_data;
        end
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W)
    ) u_sb (
        .clock    (clock),
        .reset    (reset),
        .flush    (!is_ready || clear_req),
        .set_en   (rsv_fire),
        .set_addr (rsv_addr),
        .clr_en   (wr_fire),
        .clr_addr (wr_addr),
        .busy     (busy)
    );

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              nz;
        logic              hit;

        assign ra  = rd_addr[i*ADDR_W +: ADDR_W];
        assign nz  = (ra != '0);
        assign hit = wr_fire && (wr_addr == ra);

        // A same-cycle write forwards its data and supersedes any busy flag.
        assign rd_data[i*DATA_W +: DATA_W] =
            (!is_ready || !nz) ? '0 :
            hit                ? wr_data :
                                 regs[ra];
        assign rd_busy[i] = is_ready && nz && !hit && busy[ra];
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5: address width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL have parameter NUM_RD, default 2: number of independent read ports.
REQ-004 SHALL have port clock  input  1: all state updates on rising edge.
REQ-005 SHALL have port reset  input  1: reset, synchronous, active-high.
REQ-006 SHALL have port clear_req  input  1: one-cycle pulse starting a soft clear sweep.
REQ-007 SHALL have port rd_addr  input  NUM_RD*ADDR_W: read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
REQ-008 SHALL have port rd_data  output  NUM_RD*DATA_W: read data, packed like rd_addr.
REQ-009 SHALL have port rd_busy  output  NUM_RD: 1 = the addressed register has a pending producer.
REQ-010 SHALL have port wr_en  input  1: write strobe.
REQ-011 SHALL have port wr_addr  input  ADDR_W: write address.
REQ-012 SHALL have port wr_data  input  DATA_W: write data.
REQ-013 SHALL have port rsv_en  input  1: reserve strobe, marking a register busy.
REQ-014 SHALL have port rsv_addr  input  ADDR_W: address to reserve.
REQ-015 SHALL have port ready  output  1: 1 = clear sweep complete, block accepting operations.

Function
REQ-016 SHALL implement a two-state FSM: CLEAR (sweep in progress) and READY.
REQ-017 In CLEAR, entry clr_idx SHALL be written to 0 each cycle; clr_idx counts 0..DEPTH-1; the transition to READY SHALL occur on the edge that clears entry DEPTH-1.
REQ-018 A clear sweep SHALL take exactly DEPTH cycles; ready SHALL be 0 throughout CLEAR and 1 only in READY.
REQ-019 In CLEAR, wr_en and rsv_en SHALL be ignored, all busy bits SHALL be 0, and all rd_data and rd_busy SHALL read 0.
REQ-020 clear_req in READY SHALL move to CLEAR with clr_idx=0 on the next edge; clear_req in CLEAR SHALL restart the sweep at clr_idx=0.
REQ-021 In READY, wr_en with wr_addr!=0 SHALL write wr_data on the rising edge; writes to address 0 SHALL be discarded.
REQ-022 Read ports SHALL be combinational; address 0 SHALL always read 0 with rd_busy 0.
REQ-023 Bypass: if wr_en, READY, wr_addr==rd_addr[i] and rd_addr[i]!=0, rd_data[i] SHALL equal wr_data in the same cycle and rd_busy[i] SHALL be 0.
REQ-024 rsv_en with rsv_addr!=0 in READY SHALL set busy[rsv_addr] on the next edge; reserving address 0 SHALL have no effect.
REQ-025 A write to address A SHALL clear busy[A] on the same edge.
REQ-026 Simultaneous write and reserve to the same address SHALL leave busy set (reserve wins) and store the data.
REQ-027 Write and reserve to different addresses in one cycle SHALL both take effect independently.
REQ-028 Reserving an already-busy register SHALL keep it busy; there is no counting of producers.
REQ-029 All NUM_RD ports SHALL operate independently, including on identical addresses.

Reset
REQ-030 reset SHALL have priority over every other input, including clear_req.
REQ-031 reset SHALL force state CLEAR, clr_idx=0, all busy bits 0, and ready 0 on the same edge.
REQ-032 Asserting reset mid-sweep or mid-operation SHALL restart a full DEPTH-cycle sweep after reset deasserts.
REQ-033 Register contents SHALL be guaranteed 0 only after ready rises.

Structure
REQ-034 The FSM state encoding and the default values of DATA_W and ADDR_W SHALL reside in shared package mips32_pkg.
REQ-035 The busy-bit array with its set/clear priority logic SHALL be sub-module regfile_scoreboard.
REQ-036 The storage and read/bypass logic SHALL remain in regfile_sb.

Verification
REQ-037 reset 1 cycle -> ready stays 0 for 32 cycles and rises on cycle 32; then read of any address returns 0.
REQ-038 Write 0xDEADBEEF to reg 7 while rd_addr[0]=7 -> rd_data[0]=0xDEADBEEF in the same cycle (bypass) and the value holds on later reads.
REQ-039 Write 0x12345678 to reg 0 -> a read of reg 0 returns 0; rsv_en to reg 0 -> rd_busy stays 0.
REQ-040 Reserve reg 5 -> rd_busy=1 on the next cycle; then write reg 5 with rsv_en=1 on reg 5 in the same cycle -> busy stays 1; write again without reserve -> busy 0.
REQ-041 clear_req at sweep index 10 of a prior clear, with regs 3 and 31 written -> sweep restarts, ready low for 32 cycles, regs 3 and 31 read 0, wr_en ignored during the sweep.
REQ-042 NUM_RD=3, DATA_W=16, ADDR_W=3 instance -> ready rises after 8 cycles and all three ports independently read the written patterns 0xA5A5, 0x5A5A and 0x0F0F.
